// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one row at a time, debounces
// press and release of a single key, and holds the captured one-hot
// row/column pair for the downstream one-hot keypad decoder.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_drive,
  output logic [3:0] key_rows,
  output logic [3:0] key_cols,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        sync1_q, sync1_d;
  logic [3:0]        sync2_q, sync2_d;
  logic [3:0]        row_q, row_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]        cap_row_q, cap_row_d;
  logic [3:0]        cap_col_q, cap_col_d;
  logic [3:0]        key_rows_q, key_rows_d;
  logic [3:0]        key_cols_q, key_cols_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

  logic [3:0] col_sync;
  logic       col_onehot;
  logic       cap_bit;
  logic [3:0] row_next;

  // Derived views of the synchronized columns and the next row in rotation.
  always_comb begin
    col_sync   = sync2_q;
    col_onehot = (col_sync != 4'd0) && ((col_sync & (col_sync - 4'd1)) == 4'd0);
    cap_bit    = |(col_sync & cap_col_q);
    row_next   = {row_q[2:0], row_q[3]};
  end

  // Scan/debounce FSM: next state, counters, capture registers and key outputs.
  always_comb begin
    state_d     = state_q;
    sync1_d     = col_in;
    sync2_d     = sync1_q;
    row_d       = row_q;
    scan_cnt_d  = scan_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    cap_row_d   = cap_row_q;
    cap_col_d   = cap_col_q;
    key_rows_d  = key_rows_q;
    key_cols_d  = key_cols_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      ST_SCAN: begin
        if (col_onehot) begin
          cap_row_d = row_q;
          cap_col_d = col_sync;
          deb_cnt_d = '0;
          state_d   = ST_DEBOUNCE;
        end else if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          row_d      = row_next;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (col_sync == cap_col_q) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d     = ST_HELD;
            key_rows_d  = cap_row_q;
            key_cols_d  = cap_col_q;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else begin
          state_d    = ST_SCAN;
          scan_cnt_d = '0;
        end
      end

      ST_HELD: begin
        if (!cap_bit) begin
          deb_cnt_d = '0;
          state_d   = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (cap_bit) begin
          state_d = ST_HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = ST_SCAN;
          key_held_d = 1'b0;
          row_d      = row_next;
          scan_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any state on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      sync1_q     <= 4'd0;
      sync2_q     <= 4'd0;
      row_q       <= 4'b0001;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      cap_row_q   <= 4'd0;
      cap_col_q   <= 4'd0;
      key_rows_q  <= 4'd0;
      key_cols_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      row_q       <= row_d;
      scan_cnt_q  <= scan_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      cap_row_q   <= cap_row_d;
      cap_col_q   <= cap_col_d;
      key_rows_q  <= key_rows_d;
      key_cols_q  <= key_cols_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row_drive = row_q;
  assign key_rows  = key_rows_q;
  assign key_cols  = key_cols_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed, table-driven bench for keypad_scanner with a
// small 4x4 key-matrix model that turns pressed keys plus row_drive into col_in.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_drive;
  logic [3:0]  key_rows;
  logic [3:0]  key_cols;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0000;
  logic        inv_en = 1'b0;
  logic        prev_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [15:0] keys;
    logic [3:0]  row;
    logic        valid;
    logic        held;
    logic [3:0]  krow;
    logic [3:0]  kcol;
  } vec_t;

  vec_t vecs [0:41];

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .col_in(col_in),
    .row_drive(row_drive),
    .key_rows(key_rows),
    .key_cols(key_cols),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Key matrix model: keys[r*4+c] closed connects row r to column c.
  always_comb begin
    col_in = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (row_drive[r]) col_in = col_in | keys[r*4 +: 4];
    end
  end

  // Structural invariants watched on every falling edge once out of reset.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if (!$onehot(row_drive)) begin
        errors++;
        $display("[TB] FAIL inv_row_onehot: row_drive=%b, expected one-hot", row_drive);
      end
      checks++;
      if (key_valid && (!key_held || prev_valid)) begin
        errors++;
        $display("[TB] FAIL inv_valid: valid=%b held=%b prev_valid=%b, expected held=1 prev_valid=0", key_valid, key_held, prev_valid);
      end
      prev_valid = key_valid;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [3:0] scanRow(input int c);
    return 4'(4'b0001 << ((c / SCAN_DIV) % 4));
  endfunction

  function automatic vec_t mkVec(input logic r, input logic [15:0] k, input logic [3:0] er,
                                 input logic ev, input logic eh, input logic [3:0] ekr,
                                 input logic [3:0] ekc);
    vec_t v;
    v.rst = r; v.keys = k; v.row = er; v.valid = ev; v.held = eh; v.krow = ekr; v.kcol = ekc;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic [15:0] k);
    @(negedge clk);
    reset = r;
    keys  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] er, input logic ev,
                             input logic eh, input logic [3:0] ekr, input logic [3:0] ekc);
    checks++;
    if ({row_drive, key_valid, key_held, key_rows, key_cols} !== {er, ev, eh, ekr, ekc}) begin
      errors++;
      $display("[TB] FAIL %s: got row=%b valid=%b held=%b rows=%b cols=%b, expected row=%b valid=%b held=%b rows=%b cols=%b",
               name, row_drive, key_valid, key_held, key_rows, key_cols, er, ev, eh, ekr, ekc);
    end
  endtask

  initial begin
    // Idle scanning after reset, then the "5" key (row 1, col 1) from reset.
    vecs[0] = mkVec(1'b1, 16'h0000, 4'b0001, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int c = 1; c <= 20; c++)
      vecs[c] = mkVec(1'b0, 16'h0000, scanRow(c), 1'b0, 1'b0, 4'd0, 4'd0);
    vecs[21] = mkVec(1'b1, 16'h0020, 4'b0001, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int c = 1; c <= 20; c++)
      vecs[21 + c] = mkVec(1'b0, 16'h0020, (c < 4) ? 4'b0001 : 4'b0010, c == 15, c >= 15,
                           (c >= 15) ? 4'b0010 : 4'd0, (c >= 15) ? 4'b0010 : 4'd0);

    $display("[TB] table: idle scan and key 5");
    for (int i = 0; i < 42; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].keys);
      checkOutput($sformatf("table[%0d]", i), vecs[i].row, vecs[i].valid, vecs[i].held,
                  vecs[i].krow, vecs[i].kcol);
      if (i == 0) inv_en = 1'b1;
    end

    $display("[TB] second key while held, then release");
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b0, 16'h00A0);
      checkOutput($sformatf("second_key c%0d", i), 4'b0010, 1'b0, 1'b1, 4'b0010, 4'b0010);
    end
    for (int f = 1; f <= 15; f++) begin
      applyStimulus(1'b0, 16'h0000);
      checkOutput($sformatf("release c%0d", f),
                  (f <= 10) ? 4'b0010 : ((f <= 14) ? 4'b0100 : 4'b1000),
                  1'b0, f <= 10, 4'b0010, 4'b0010);
    end

    $display("[TB] bouncing press on row 0 col 2");
    applyStimulus(1'b1, 16'h0000);
    checkOutput("bounce_reset", 4'b0001, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int k = 0; k <= 21; k++) begin
      int c;
      logic on;
      c  = k + 1;
      on = (k < 2) || (k >= 4 && k < 6) || (k >= 8);
      applyStimulus(1'b0, on ? 16'h0004 : 16'h0000);
      checkOutput($sformatf("bounce c%0d", c), 4'b0001, c == 19, c >= 19,
                  (c >= 19) ? 4'b0001 : 4'd0, (c >= 19) ? 4'b0100 : 4'd0);
    end

    $display("[TB] two keys in one row, then one removed");
    applyStimulus(1'b1, 16'h0000);
    checkOutput("multi_reset", 4'b0001, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int k = 0; k <= 30; k++) begin
      int c;
      c = k + 1;
      applyStimulus(1'b0, (k < 8) ? 16'h0003 : 16'h0001);
      checkOutput($sformatf("multi c%0d", c), (c <= 18) ? scanRow(c) : 4'b0001, c == 27, c >= 27,
                  (c >= 27) ? 4'b0001 : 4'd0, (c >= 27) ? 4'b0001 : 4'd0);
    end

    $display("[TB] reset during debounce and during held");
    applyStimulus(1'b1, 16'h0000);
    checkOutput("rst_seq_reset", 4'b0001, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int k = 0; k <= 3; k++) begin
      applyStimulus(1'b0, 16'h0001);
      checkOutput($sformatf("rst_a c%0d", k + 1), 4'b0001, 1'b0, 1'b0, 4'd0, 4'd0);
    end
    applyStimulus(1'b1, 16'h0001);
    checkOutput("rst_in_debounce", 4'b0001, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int k = 0; k <= 12; k++) begin
      int c;
      c = k + 1;
      applyStimulus(1'b0, 16'h0001);
      checkOutput($sformatf("rst_b c%0d", c), 4'b0001, c == 11, c >= 11,
                  (c >= 11) ? 4'b0001 : 4'd0, (c >= 11) ? 4'b0001 : 4'd0);
    end
    applyStimulus(1'b1, 16'h0001);
    checkOutput("rst_in_held", 4'b0001, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int k = 0; k <= 7; k++) begin
      applyStimulus(1'b0, 16'h0000);
      checkOutput($sformatf("rst_c c%0d", k + 1), scanRow(k + 1), 1'b0, 1'b0, 4'd0, 4'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Sequences a 4x4 matrix keypad: drives one row at a time, samples the asynchronous column lines, debounces press and release, and holds the captured one-hot row/column pair.
- The held pair feeds the existing one-hot keypad decoder, which maps it to a 4-bit key code.
- Emits a one-cycle key_valid strobe per debounced press. Rejects multi-key presses while scanning and ignores second keys while a key is held.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven during scanning; must be >= 2.
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- col_in  input  4  raw column lines, asynchronous, active-high (1 = key in driven row closed)
- row_drive  output  4  one-hot row drive to keypad, active-high
- key_rows  output  4  captured one-hot row, to decoder rows input
- key_cols  output  4  captured one-hot column, to decoder cols input
- key_valid  output  1  one-cycle strobe on each accepted press
- key_held  output  1  high while the accepted key is considered pressed

Behaviour:
- Synchronizer:
  - col_in passes through a 2-flop synchronizer to produce col_sync. Only col_sync is used internally.
  - Both flops reset to 0.
- Reset values:
  - State SCAN, row_drive = 0001, scan counter = 0, debounce counter = 0.
  - key_rows = 0000, key_cols = 0000 (decoder reads 0), key_valid = 0, key_held = 0.
  - Reset mid-operation aborts any state immediately on the next edge.
- SCAN:
  - The scan counter increments each cycle. At SCAN_DIV-1 it wraps to 0 and row_drive rotates left: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - If col_sync is exactly one-hot in any cycle: capture row_drive into cap_row and col_sync into cap_col, freeze row_drive, clear the debounce counter, go to DEBOUNCE.
  - If col_sync has 0 bits or 2 or more bits set: keep scanning. This is multi-key rejection.
- DEBOUNCE:
  - row_drive is frozen.
  - Each cycle col_sync == cap_col, the counter increments. Any cycle it differs returns to SCAN with the same row, scan counter cleared, and key outputs unchanged.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a match, go to HELD.
  - On entry to HELD, in the same edge: key_rows <= cap_row, key_cols <= cap_col.
  - key_valid = 1 for exactly the first HELD cycle. key_held = 1 from that cycle on.
- HELD:
  - row_drive is frozen. Only bit cap_col of col_sync is examined; other column bits (a second key) are ignored.
  - If that bit is 0: clear the debounce counter, go to RELEASE.
- RELEASE:
  - key_held stays 1.
  - While the cap_col bit is 0, the counter increments. If the bit returns to 1, go back to HELD with no new key_valid.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the bit 0: go to SCAN, key_held <= 0, row_drive advances to the next row, scan counter cleared.
  - key_rows and key_cols keep the last key until the next accepted press.
- Latency:
  - Cycle 0 is the first cycle col_sync is one-hot in SCAN. DEBOUNCE is entered at cycle 1. key_valid is asserted at cycle DEBOUNCE_CYCLES+1.
  - col_in to col_sync adds 2 cycles.
- Invariants:
  - row_drive is always one-hot.
  - key_valid is never high on two consecutive cycles.
  - key_valid implies key_held.
  - Counter widths are $clog2 of the respective parameter (minimum 1 bit). Counters never exceed their terminal value.

Test Plan:
(SCAN_DIV=4, DEBOUNCE_CYCLES=8)
1. Reset, col_in=0 for 20 cycles -> row_drive 0001,0010,0100,1000,0001 in 4-cycle steps; key_valid and key_held stay 0; key_rows and key_cols stay 0000.
2. Model the "5" key: col_in=0010 whenever row_drive=0010, held steady -> exactly one key_valid pulse, 9 cycles after col_sync first goes one-hot; key_rows=0010, key_cols=0010; key_held=1; row_drive frozen at 0010.
3. Press with a 3-cycle bounce (col_in toggles 0100/0000 every 2 cycles on row 0001, then steady) -> no key_valid during bounce; exactly one pulse after the stable run; key_cols=0100.
4. With the key from scenario 2 held, add a second key at col 1000 -> no additional key_valid; key_cols stays 0010. Then release both for 10 cycles -> key_held falls; scanning resumes at row 0100.
5. Two keys in the same row (col_in=0011 on row 0001) -> no capture, scanning continues. Then remove col 1 -> capture with key_cols=0001.
6. Assert reset during DEBOUNCE and during HELD -> the next cycle shows all reset values and row_drive=0001; no key_valid is emitted.
